// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared breakout grid geometry and scanner state encoding
// Purpose : constants describing the brick grid and ball size, reused by the
//           collision scanner, renderer and ball controller; scanner FSM enum.
// Ports   : none (package)
package breakout_pkg;

    localparam int ROWS       = 5;
    localparam int COLS       = 12;
    localparam int LEFT_X     = 250;
    localparam int TOP_Y      = 35;
    localparam int BRICK_W    = 45;
    localparam int BRICK_H    = 25;
    localparam int BALL_R     = 5;
    localparam int NUM_BRICKS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/brick_hit_scanner_if.sv
// rtl/brick_hit_scanner_if.sv - control, result and renderer lookup bundle of the brick scanner
// Purpose : groups the tick handshake, ball position, scan results and the
//           renderer alive lookup.
// Ports   : master = game controller / renderer side, slave = scanner side.
interface brick_hit_scanner_if;

    logic       start;
    logic       refill;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       busy;
    logic       done;
    logic       hit;
    logic       flip_x;
    logic       flip_y;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic [5:0] bricks_left;
    logic       all_clear;
    logic [2:0] rd_row;
    logic [3:0] rd_col;
    logic       rd_alive;

    modport master (
        output start, refill, ball_x, ball_y, rd_row, rd_col,
        input  busy, done, hit, flip_x, flip_y, hit_row, hit_col,
               bricks_left, all_clear, rd_alive
    );

    modport slave (
        input  start, refill, ball_x, ball_y, rd_row, rd_col,
        output busy, done, hit, flip_x, flip_y, hit_row, hit_col,
               bricks_left, all_clear, rd_alive
    );

endinterface

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational inclusive 2-D box intersection test
// Purpose : reports whether two axis-aligned boxes share at least one pixel;
//           all bounds inclusive, operands signed so boxes may extend left of 0.
// Ports   : a_*  box A bounds (lo/hi per axis)
//           b_*  box B bounds (lo/hi per axis)
//           overlap  1 when the boxes intersect
module box_overlap #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] a_x_lo,
    input  logic signed [WIDTH-1:0] a_x_hi,
    input  logic signed [WIDTH-1:0] a_y_lo,
    input  logic signed [WIDTH-1:0] a_y_hi,
    input  logic signed [WIDTH-1:0] b_x_lo,
    input  logic signed [WIDTH-1:0] b_x_hi,
    input  logic signed [WIDTH-1:0] b_y_lo,
    input  logic signed [WIDTH-1:0] b_y_hi,
    output logic                    overlap
);

    assign overlap = (b_x_lo <= a_x_hi) && (a_x_lo <= b_x_hi) &&
                     (b_y_lo <= a_y_hi) && (a_y_lo <= b_y_hi);

endmodule

// File: rtl/brick_hit_scanner.sv
// rtl/brick_hit_scanner.sv - sequential ball-vs-brick collision scanner and brick alive store
// Purpose : after each game tick, walks the 5x12 grid one brick per clock,
//           destroys the first live brick touched by the ball box and reports
//           it once with the bounce axis; holds the alive bits for rendering.
// Ports   : clk, rst (async, active-high)
//           bus.slave : start/refill/ball_x/ball_y in; busy/done/hit/flip_x/
//                       flip_y/hit_row/hit_col/bricks_left/all_clear out;
//                       rd_row/rd_col in, rd_alive out (combinational)
module brick_hit_scanner
    import breakout_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    brick_hit_scanner_if.slave bus
);

    localparam logic signed [10:0] LEFT_S  = 11'(LEFT_X);
    localparam logic signed [10:0] TOP_S   = 11'(TOP_Y);
    localparam logic signed [10:0] W_S     = 11'(BRICK_W);
    localparam logic signed [10:0] H_S     = 11'(BRICK_H);
    localparam logic signed [10:0] W_M1_S  = 11'(BRICK_W - 1);
    localparam logic signed [10:0] H_M1_S  = 11'(BRICK_H - 1);
    localparam logic signed [10:0] R_S     = 11'(BALL_R);
    localparam logic [5:0]         FULL    = 6'(NUM_BRICKS);

    scan_state_t state, state_next;

    logic [NUM_BRICKS-1:0] alive;
    logic [5:0]            idx;
    logic [2:0]            row;
    logic [3:0]            col;
    logic signed [10:0]    cap_x, cap_y;
    logic signed [10:0]    bx, by;
    logic signed [10:0]    bx_hi, by_hi;
    logic                  overlap, qualify, last_brick, x_inside;
    logic [5:0]            bricks_left;
    logic                  all_clear_q;
    logic                  hit_q, flip_x_q, flip_y_q;
    logic [2:0]            hit_row_q;
    logic [3:0]            hit_col_q;
    logic                  rd_in_range;
    logic [5:0]            rd_idx;

    assign bx_hi = bx + W_M1_S;
    assign by_hi = by + H_M1_S;

    // Ball inputs are widened to 11-bit signed so x-R / y-R stay correct near 0.
    box_overlap #(.WIDTH(11)) u_overlap (
        .a_x_lo (cap_x - R_S),
        .a_x_hi (cap_x + R_S),
        .a_y_lo (cap_y - R_S),
        .a_y_hi (cap_y + R_S),
        .b_x_lo (bx),
        .b_x_hi (bx_hi),
        .b_y_lo (by),
        .b_y_hi (by_hi),
        .overlap(overlap)
    );

    assign qualify    = (state == SCAN) && alive[idx] && overlap;
    assign last_brick = (idx == 6'(NUM_BRICKS - 1));
    // Ball centre within the brick's column span means it struck a top/bottom face.
    assign x_inside   = (cap_x >= bx) && (cap_x <= bx_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (qualify || last_brick) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.refill) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive       <= '1;
            bricks_left <= FULL;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            cap_x       <= '0;
            cap_y       <= '0;
            bx          <= LEFT_S;
            by          <= TOP_S;
            hit_q       <= 1'b0;
            flip_x_q    <= 1'b0;
            flip_y_q    <= 1'b0;
            hit_row_q   <= '0;
            hit_col_q   <= '0;
        end else if (bus.refill) begin
            alive       <= '1;
            bricks_left <= FULL;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cap_x     <= $signed({1'b0, bus.ball_x});
                        cap_y     <= $signed({1'b0, bus.ball_y});
                        idx       <= '0;
                        row       <= '0;
                        col       <= '0;
                        bx        <= LEFT_S;
                        by        <= TOP_S;
                        hit_q     <= 1'b0;
                        flip_x_q  <= 1'b0;
                        flip_y_q  <= 1'b0;
                        hit_row_q <= '0;
                        hit_col_q <= '0;
                    end
                end
                SCAN: begin
                    if (qualify) begin
                        alive[idx] <= 1'b0;
                        if (bricks_left != '0) bricks_left <= bricks_left - 6'd1;
                        hit_q     <= 1'b1;
                        hit_row_q <= row;
                        hit_col_q <= col;
                        flip_y_q  <= x_inside;
                        flip_x_q  <= !x_inside;
                    end else if (!last_brick) begin
                        // Running edge accumulators replace row*H / col*W products.
                        idx <= idx + 6'd1;
                        if (col == 4'(COLS - 1)) begin
                            col <= '0;
                            bx  <= LEFT_S;
                            row <= row + 3'd1;
                            by  <= by + H_S;
                        end else begin
                            col <= col + 4'd1;
                            bx  <= bx + W_S;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_clear_q <= 1'b0;
        end else begin
            all_clear_q <= (bricks_left == '0);
        end
    end

    // rd_row*12 + rd_col as shift-add: row*8 + row*4 + col.
    assign rd_in_range = (bus.rd_row < 3'(ROWS)) && (bus.rd_col < 4'(COLS));
    assign rd_idx      = {bus.rd_row, 3'b000} + {1'b0, bus.rd_row, 2'b00} + {2'b00, bus.rd_col};
    assign bus.rd_alive = rd_in_range ? alive[rd_idx] : 1'b0;

    assign bus.busy        = (state == SCAN);
    assign bus.done        = (state == REPORT);
    assign bus.hit         = hit_q;
    assign bus.flip_x      = flip_x_q;
    assign bus.flip_y      = flip_y_q;
    assign bus.hit_row     = hit_row_q;
    assign bus.hit_col     = hit_col_q;
    assign bus.bricks_left = bricks_left;
    assign bus.all_clear   = all_clear_q;

endmodule

// File: tb/tb_brick_hit_scanner.sv
// tb/tb_brick_hit_scanner.sv - randomized self-checking bench for brick_hit_scanner
module tb_brick_hit_scanner;
    import breakout_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    brick_hit_scanner_if bus();

    brick_hit_scanner dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit model_alive [ROWS][COLS];
    int model_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_refill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model_alive[r][c] = 1'b1;
        model_left = NUM_BRICKS;
    endtask

    // First live brick in row-major order whose rectangle meets the ball box.
    task automatic model_scan(input int x, input int y, output int k, output int hit,
                              output int hr, output int hc, output int fx, output int fy);
        k = -1; hit = 0; hr = 0; hc = 0; fx = 0; fy = 0;
        for (int r = 0; r < ROWS && k < 0; r++) begin
            for (int c = 0; c < COLS && k < 0; c++) begin
                int bl, bt, br, bb;
                bl = LEFT_X + c * BRICK_W;
                br = bl + BRICK_W - 1;
                bt = TOP_Y + r * BRICK_H;
                bb = bt + BRICK_H - 1;
                if (model_alive[r][c] && bl <= x + BALL_R && x - BALL_R <= br &&
                    bt <= y + BALL_R && y - BALL_R <= bb) begin
                    k = r * COLS + c;
                    hit = 1; hr = r; hc = c;
                    fy = (x >= bl && x <= br) ? 1 : 0;
                    fx = 1 - fy;
                    model_alive[r][c] = 1'b0;
                    if (model_left > 0) model_left--;
                end
            end
        end
    endtask

    task automatic do_refill();
        @(negedge clk);
        bus.refill = 1'b1;
        @(posedge clk);
        #1 bus.refill = 1'b0;
        model_refill();
    endtask

    task automatic check_rd(input int r, input int c);
        int exp;
        bus.rd_row = 3'(r);
        bus.rd_col = 4'(c);
        #1;
        exp = (r < ROWS && c < COLS) ? int'(model_alive[r][c]) : 0;
        check("rd_alive", 32'(bus.rd_alive), 32'(exp));
    endtask

    // Launches a scan; optionally pokes a second start mid-scan that must be ignored.
    task automatic run_scan(input int x, input int y, input bit poke);
        int k, hit, hr, hc, fx, fy, exp_e, e, busy_cnt;
        bit seen;
        model_scan(x, y, k, hit, hr, hc, fx, fy);
        exp_e = hit ? k + 1 : NUM_BRICKS;
        @(negedge clk);
        bus.ball_x = 10'(x);
        bus.ball_y = 10'(y);
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.ball_x = 10'($urandom_range(0, 1023));
        bus.ball_y = 10'($urandom_range(0, 1023));
        seen = 1'b0;
        busy_cnt = 0;
        for (e = 0; e < 70; e++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (poke && e == 5) begin
                bus.ball_x = 10'd272;
                bus.ball_y = 10'd47;
                bus.start  = 1'b1;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency", 32'(e), 32'(exp_e));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_e));
        check("hit", 32'(bus.hit), 32'(hit));
        check("flip_x", 32'(bus.flip_x), 32'(fx));
        check("flip_y", 32'(bus.flip_y), 32'(fy));
        check("hit_row", 32'(bus.hit_row), 32'(hr));
        check("hit_col", 32'(bus.hit_col), 32'(hc));
        check("bricks_left", 32'(bus.bricks_left), 32'(model_left));
        check("busy_in_report", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        if (hit) check_rd(hr, hc);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        bus.start = 1'b0; bus.refill = 1'b0;
        bus.ball_x = '0;  bus.ball_y = '0;
        bus.rd_row = '0;  bus.rd_col = '0;
        model_refill();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_bricks_left", 32'(bus.bricks_left), 32'd60);
        check("rst_all_clear", 32'(bus.all_clear), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check_rd(4, 11);
        check_rd(5, 0);
        check_rd(0, 12);

        // Directed scans
        run_scan(450, 400, 1'b0);
        run_scan(272, 47, 1'b0);
        run_scan(272, 47, 1'b0);
        do_refill();
        run_scan(296, 47, 1'b0);
        run_scan(2, 47, 1'b0);

        // Refill aborts a scan with a pending hit on brick (1,0)
        do_refill();
        @(negedge clk);
        bus.ball_x = 10'd272; bus.ball_y = 10'd72; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.refill = 1'b1;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.refill = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bricks_left", 32'(bus.bricks_left), 32'd60);
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check_rd(1, 0);

        // start while busy is ignored
        run_scan(450, 400, 1'b1);
        check_rd(0, 0);

        // Randomized scans
        do_refill();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) do_refill();
            run_scan($urandom_range(230, 820), $urandom_range(20, 190), 1'b0);
            check_rd($urandom_range(0, 7), $urandom_range(0, 15));
        end

        // Clear the whole grid with targeted hits
        do_refill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                run_scan(LEFT_X + c * BRICK_W + 22, TOP_Y + r * BRICK_H + 12, 1'b0);
        check("clear_bricks_left", 32'(bus.bricks_left), 32'd0);
        check("clear_all_clear", 32'(bus.all_clear), 32'd1);
        run_scan(272, 47, 1'b0);
        check("clear_still_zero", 32'(bus.bricks_left), 32'd0);
        check("clear_all_clear2", 32'(bus.all_clear), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
